// File: rtl/dff_arbiter.sv
// Four-requester round-robin arbiter that loads a shared data register.
// The grant, load and hold phases are sequenced by a small registered FSM.
module dff_arbiter #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] d_in,
    input  logic               clr,
    output logic [3:0]         gnt,
    output logic [WIDTH-1:0]   q,
    output logic [1:0]         q_owner,
    output logic               q_valid,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       gnt_q;
    logic [WIDTH-1:0] q_q;
    logic [1:0]       owner_q;
    logic             valid_q;
    logic [1:0]       last_q;
    logic [3:0]       cnt_q;

    logic [1:0]       win_d;
    logic [1:0]       idx;
    logic             found;

    // Search starts one past the previous winner and wraps 3 -> 0.
    always_comb begin
        win_d = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                win_d = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'd0;
            q_q     <= '0;
            owner_q <= 2'd0;
            valid_q <= 1'b0;
            last_q  <= 2'd3;
            cnt_q   <= 4'd0;
        end else begin
            if (clr) begin
                q_q     <= '0;
                valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= GRANT;
                        gnt_q   <= 4'd1 << win_d;
                        last_q  <= win_d;
                    end else begin
                        gnt_q   <= 4'd0;
                    end
                end
                GRANT: begin
                    gnt_q <= 4'd0;
                    // last_q already holds the winner; a dropped request
                    // or a clear aborts the load.
                    if (req[last_q] && !clr) begin
                        q_q     <= d_in[last_q*WIDTH +: WIDTH];
                        owner_q <= last_q;
                        valid_q <= 1'b1;
                        cnt_q   <= 4'(HOLD_CYCLES - 1);
                        state_q <= HOLD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_owner = owner_q;
    assign q_valid = valid_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dff_arbiter.sv
// Directed bench for dff_arbiter: grant order, load timing, abort,
// clear and asynchronous reset, plus per-cycle grant/q invariants.
module tb_dff_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [3:0]     req;
    logic [4*W-1:0] d_in;
    logic           clr;
    logic [3:0]     gnt;
    logic [W-1:0]   q;
    logic [1:0]     q_owner;
    logic           q_valid;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    dff_arbiter #(.WIDTH(W), .HOLD_CYCLES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d_in    (d_in),
        .clr     (clr),
        .gnt     (gnt),
        .q       (q),
        .q_owner (q_owner),
        .q_valid (q_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_q"}, 32'(q), 0);
        chk({tag, "_own"}, 32'(q_owner), 0);
        chk({tag, "_val"}, 32'(q_valid), 0);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    logic [W-1:0] pq = '0;
    logic [3:0]   pg = '0;
    logic         pc = 1'b0;

    // Invariants, sampled away from the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("onehot", 32'($onehot0(gnt)), 1);
            chk("gnt_busy", 32'((gnt == 4'd0) || busy), 1);
            if (q !== pq)
                chk("q_cause", 32'((pg != 4'd0) || pc), 1);
        end
        pq = q;
        pg = gnt;
        pc = clr;
    end

    initial begin
        req  = 4'd0;
        d_in = '0;
        clr  = 1'b0;
        #12;
        chk_reset("rst0");
        rst = 1'b1;

        // single request
        d_in[16 +: 8] = 8'hA5;
        d_in[0 +: 8]  = 8'h11;
        req = 4'b0100;
        tick;
        chk("t1_gnt", 32'(gnt), 32'b0100);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_qpre", 32'(q), 0);
        tick;
        chk("t1_q", 32'(q), 32'hA5);
        chk("t1_own", 32'(q_owner), 2);
        chk("t1_val", 32'(q_valid), 1);
        chk("t1_gnt0", 32'(gnt), 0);
        req = 4'd0;
        tick;
        chk("t1_hold", 32'(busy), 1);
        tick;
        chk("t1_idle", 32'(busy), 0);

        rst = 1'b0;
        #4;
        rst = 1'b1;

        // fairness: loads every 4 cycles, order 0,1,2,3,0
        d_in = 32'h44332211;
        req  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("fair%0d_gnt", k), 32'(gnt), 32'(1 << (k % 4)));
            tick;
            chk($sformatf("fair%0d_q", k), 32'(q), 32'(8'h11 * (k % 4 + 1)));
            chk($sformatf("fair%0d_own", k), 32'(q_owner), 32'(k % 4));
            chk($sformatf("fair%0d_gnt0", k), 32'(gnt), 0);
            tick;
            tick;
            chk($sformatf("fair%0d_idle", k), 32'(busy), 0);
        end
        req = 4'd0;

        // abort: request dropped during GRANT
        req = 4'b0010;
        tick;
        chk("ab_gnt", 32'(gnt), 32'b0010);
        req = 4'd0;
        tick;
        chk("ab_gnt0", 32'(gnt), 0);
        chk("ab_busy", 32'(busy), 0);
        chk("ab_q", 32'(q), 32'h11);
        chk("ab_own", 32'(q_owner), 0);
        chk("ab_val", 32'(q_valid), 1);

        // clear during HOLD
        d_in[24 +: 8] = 8'h3C;
        req = 4'b1000;
        tick;
        chk("ch_gnt", 32'(gnt), 32'b1000);
        tick;
        chk("ch_q", 32'(q), 32'h3C);
        chk("ch_own", 32'(q_owner), 3);
        req = 4'd0;
        clr = 1'b1;
        tick;
        chk("ch_qclr", 32'(q), 0);
        chk("ch_val", 32'(q_valid), 0);
        chk("ch_ownk", 32'(q_owner), 3);
        chk("ch_busy", 32'(busy), 1);
        clr = 1'b0;
        tick;
        chk("ch_idle", 32'(busy), 0);

        // clear during GRANT suppresses the load
        d_in[16 +: 8] = 8'h77;
        req = 4'b0100;
        tick;
        chk("cg_gnt", 32'(gnt), 32'b0100);
        clr = 1'b1;
        tick;
        chk("cg_q", 32'(q), 0);
        chk("cg_val", 32'(q_valid), 0);
        chk("cg_own", 32'(q_owner), 3);
        chk("cg_gnt0", 32'(gnt), 0);
        chk("cg_busy", 32'(busy), 0);
        clr = 1'b0;
        req = 4'd0;

        // async reset in HOLD
        d_in[8 +: 8] = 8'h5A;
        req = 4'b0010;
        tick;
        chk("ar_gnt", 32'(gnt), 32'b0010);
        tick;
        chk("ar_q", 32'(q), 32'h5A);
        chk("ar_own", 32'(q_owner), 1);
        req = 4'hF;
        #2;
        rst = 1'b0;
        #1;
        chk_reset("ar");
        #1;
        rst = 1'b1;
        tick;
        chk("ar_gnt1", 32'(gnt), 32'b0001);
        tick;
        chk("ar_q1", 32'(q), 32'h11);
        chk("ar_own1", 32'(q_owner), 0);
        req = 4'd0;
        tick;
        tick;
        chk("ar_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
